uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Serial UART receiver: the downstream consumer of the UartTxr line.
- Recovers 8N1 frames from a single asynchronous RX pin and delivers each byte as a one-cycle valid strobe.
- Used on hardware in loopback with UartTxr, and as the command input for the top level.
- Uses the same CLKS_PER_BIT convention as UartTxr (434 = 115200 baud at 50 MHz).

Parameters:
- CLKS_PER_BIT, 434, i_clk cycles per UART bit; legal range 8..65535.
- CTR_W, 16, bit-period counter width; must satisfy 2^CTR_W > CLKS_PER_BIT.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_rx_line  in  1  raw serial input; asynchronous to i_clk; idles high.
- o_byte  out  8  last correctly received byte; held until the next good frame.
- o_data_valid  out  1  one-cycle pulse: o_byte was updated this cycle.
- o_frame_err  out  1  one-cycle pulse: stop bit sampled low.
- o_busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async assert; release synchronous to i_clk):
  - State = IDLE; counter = 0; bit index = 0.
  - o_byte = 8'h00; o_data_valid = 0; o_frame_err = 0; o_busy = 0.
  - Synchronizer flops preset to 1 (line idle).
- Input sync:
  - i_rx_line passes through a 2-flop synchronizer, giving rx_s.
  - All decisions use rx_s only. This adds 2 cycles of latency from the pin.
- Counter:
  - Counts 0..N, where N is the per-state target.
  - Clears on every state transition.
- IDLE:
  - rx_s == 0 -> START.
- START (N = (CLKS_PER_BIT-1)/2, integer division; 216 for the default):
  - At counter == N: if rx_s == 0 -> DATA (bit index = 0).
  - Otherwise it was a glitch: return to IDLE with no output pulse.
- DATA (N = CLKS_PER_BIT-1):
  - At counter == N: shift register[bit index] = rx_s (LSB first).
  - If bit index == 7 -> STOP; else bit index + 1 and stay in DATA.
- STOP (N = CLKS_PER_BIT-1):
  - At counter == N and rx_s == 1: o_byte <= shift register; o_data_valid = 1 for exactly the next cycle; go to IDLE.
  - At counter == N and rx_s == 0: o_frame_err = 1 for exactly the next cycle; o_byte unchanged; go to BREAK.
- BREAK:
  - Wait until rx_s == 1, then go to IDLE.
  - Prevents a held-low line from producing repeated frames.
- Latency: the o_data_valid pulse comes 1 cycle after the stop-bit mid sample, i.e. about 9.5 bit periods + 3 cycles after the start-bit falling edge at the pin.
- Back-to-back frames:
  - IDLE is re-entered mid stop bit, so a start edge immediately after the stop bit is accepted.
  - No gap between frames is required.
- Pulse rules:
  - o_data_valid and o_frame_err are never high in the same cycle.
  - Neither is ever high for more than 1 cycle.
- Reset mid-frame: the partial byte is discarded, no pulse is generated, and o_byte returns to 8'h00.
- No flow control: the consumer must capture o_byte on o_data_valid. A new frame overwrites o_byte only at its own valid pulse.

Test Plan:
- Loopback: UartTxr #(16) -> uart_rx #(16), send 0x31 then 0x32 -> o_byte = 0x31 with one o_data_valid pulse, then 0x32; o_frame_err stays 0.
- Back-to-back: bench drives 0x00, 0xFF, 0xA5 with no idle gap at CLKS_PER_BIT=16 -> exactly three valid pulses, with bytes in that order.
- Glitch: i_rx_line low for 5 cycles (CLKS_PER_BIT=16, less than the half-bit of 7) -> returns to IDLE, no pulses, o_byte unchanged.
- Framing error: frame 0x5A with stop bit driven low -> one o_frame_err pulse; o_byte keeps its previous value. Line then held low for 50 bit times -> no further pulses. Line released, then 0x11 sent -> valid pulse with 0x11.
- Reset mid-frame: assert i_rst after data bit 3 of 0xC3 -> all outputs at reset values immediately, o_busy = 0. Next full frame 0x7E is received correctly.
- Default-parameter timing (434): send 0x55 -> o_data_valid rises 4124±2 cycles after the start edge at i_rx_line.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with 2-flop input sync, mid-bit sampling and framing-error detection
module uart_rx #(
   parameter int CLKS_PER_BIT = 434,
   parameter int CTR_W        = 16
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_rx_line,
   output logic [7:0] o_byte,
   output logic       o_data_valid,
   output logic       o_frame_err,
   output logic       o_busy
);
   localparam logic [CTR_W-1:0] HALF = CTR_W'((CLKS_PER_BIT - 1) / 2);
   localparam logic [CTR_W-1:0] FULL = CTR_W'(CLKS_PER_BIT - 1);
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
   state_t           state, state_n;
   logic [CTR_W-1:0] ctr, ctr_n;
   logic [2:0]       idx, idx_n;
   logic [7:0]       shreg, shreg_n, byte_n;
   logic             valid_n, ferr_n;
   logic             sync1, rx_s;
   assign o_busy = state != IDLE;
   // two-flop synchronizer, preset to the idle-high line level
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         sync1 <= 1'b1;
         rx_s  <= 1'b1;
      end else begin
         sync1 <= i_rx_line;
         rx_s  <= sync1;
      end
   end
   // state, counters, shift register and registered output strobes
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state        <= IDLE;
         ctr          <= '0;
         idx          <= '0;
         shreg        <= '0;
         o_byte       <= '0;
         o_data_valid <= 1'b0;
         o_frame_err  <= 1'b0;
      end else begin
         state        <= state_n;
         ctr          <= ctr_n;
         idx          <= idx_n;
         shreg        <= shreg_n;
         o_byte       <= byte_n;
         o_data_valid <= valid_n;
         o_frame_err  <= ferr_n;
      end
   end
   // next-state: counter runs toward the per-state sample point and clears on every transition
   always_comb begin
      state_n = state;
      ctr_n   = ctr + 1'b1;
      idx_n   = idx;
      shreg_n = shreg;
      byte_n  = o_byte;
      valid_n = 1'b0;
      ferr_n  = 1'b0;
      case (state)
         IDLE: begin
            ctr_n = '0;
            if (!rx_s) state_n = START;
         end
         START: if (ctr == HALF) begin
            ctr_n   = '0;
            idx_n   = '0;
            state_n = rx_s ? IDLE : DATA;
         end
         DATA: if (ctr == FULL) begin
            ctr_n        = '0;
            shreg_n[idx] = rx_s;
            idx_n        = idx + 3'd1;
            if (idx == 3'd7) state_n = STOP;
         end
         STOP: if (ctr == FULL) begin
            ctr_n   = '0;
            state_n = rx_s ? IDLE : BRK;
            byte_n  = rx_s ? shreg : o_byte;
            valid_n = rx_s;
            ferr_n  = !rx_s;
         end
         BRK: begin
            ctr_n = '0;
            if (rx_s) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed checks of uart_rx at 16 clocks/bit plus a default-rate latency check
module tb_uart_rx;
   logic       i_clk = 1'b0, i_rst = 1'b1, line_a = 1'b1, line_b = 1'b1;
   logic [7:0] byte_a, byte_b;
   logic       va, fa, busy_a, vb, fb, busy_b;
   int         total = 0, bad = 0;
   int         vcnt = 0, fcnt = 0, viol = 0, vb_cnt = 0, fb_cnt = 0;
   int         cyc = 0, t0b = 0, lat_b = 0;
   logic       va_p = 1'b0, fa_p = 1'b0;
   logic [7:0] got_q[$];

   uart_rx #(.CLKS_PER_BIT(16)) dut_a (
      .i_clk(i_clk), .i_rst(i_rst), .i_rx_line(line_a), .o_byte(byte_a),
      .o_data_valid(va), .o_frame_err(fa), .o_busy(busy_a));
   uart_rx dut_b (
      .i_clk(i_clk), .i_rst(i_rst), .i_rx_line(line_b), .o_byte(byte_b),
      .o_data_valid(vb), .o_frame_err(fb), .o_busy(busy_b));

   always #5 i_clk = ~i_clk;
   always @(posedge i_clk) cyc <= cyc + 1;

   // pulse scoreboard: count strobes, record bytes, flag overlapping or stretched pulses
   always @(negedge i_clk) begin
      if (va) begin
         vcnt++;
         got_q.push_back(byte_a);
      end
      if (fa) fcnt++;
      if ((va && fa) || (va && va_p) || (fa && fa_p)) viol++;
      va_p = va;
      fa_p = fa;
      if (vb) begin
         vb_cnt++;
         if (lat_b == 0) lat_b = cyc - t0b;
      end
      if (fb) fb_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge i_clk);
   endtask

   // drive the first nb bits of an 8N1 frame (start, data LSB first, stop) on line a or b
   task automatic tx(input int cpb, input bit sel, input logic [7:0] b, input bit stop, input int nb);
      logic [9:0] fr;
      fr = {stop, b, 1'b0};
      for (int i = 0; i < nb; i++) begin
         if (sel) line_b = fr[i];
         else line_a = fr[i];
         if (sel && i == 0) t0b = cyc;
         repeat (cpb) @(negedge i_clk);
      end
   endtask

   initial begin
      idle(3);
      chk("rst_byte", byte_a, 8'h00);
      chk("rst_valid", va, 0);
      chk("rst_ferr", fa, 0);
      chk("rst_busy", busy_a, 0);
      chk("rst_busy_b", busy_b, 0);
      i_rst = 1'b0;
      idle(20);
      tx(16, 0, 8'h31, 1, 10);
      idle(32);
      tx(16, 0, 8'h32, 1, 10);
      idle(40);
      chk("lb_cnt", vcnt, 2);
      chk("lb_b0", got_q[0], 8'h31);
      chk("lb_b1", got_q[1], 8'h32);
      chk("lb_ferr", fcnt, 0);
      tx(16, 0, 8'h00, 1, 10);
      tx(16, 0, 8'hFF, 1, 10);
      tx(16, 0, 8'hA5, 1, 10);
      idle(40);
      chk("b2b_cnt", vcnt, 5);
      chk("b2b_b0", got_q[2], 8'h00);
      chk("b2b_b1", got_q[3], 8'hFF);
      chk("b2b_b2", got_q[4], 8'hA5);
      line_a = 1'b0;
      idle(5);
      line_a = 1'b1;
      idle(40);
      chk("gl_cnt", vcnt, 5);
      chk("gl_byte", byte_a, 8'hA5);
      chk("gl_busy", busy_a, 0);
      tx(16, 0, 8'h5A, 0, 10);
      chk("fe_cnt", fcnt, 1);
      chk("fe_byte", byte_a, 8'hA5);
      chk("fe_vcnt", vcnt, 5);
      idle(800);
      chk("brk_fcnt", fcnt, 1);
      chk("brk_vcnt", vcnt, 5);
      chk("brk_busy", busy_a, 1);
      line_a = 1'b1;
      idle(32);
      chk("brk_exit", busy_a, 0);
      tx(16, 0, 8'h11, 1, 10);
      idle(40);
      chk("rec_cnt", vcnt, 6);
      chk("rec_b", got_q[5], 8'h11);
      chk("rec_byte", byte_a, 8'h11);
      tx(16, 0, 8'hC3, 1, 5);
      i_rst = 1'b1;
      line_a = 1'b1;
      #1;
      chk("rm_byte", byte_a, 8'h00);
      chk("rm_busy", busy_a, 0);
      chk("rm_valid", va, 0);
      chk("rm_ferr", fa, 0);
      idle(3);
      i_rst = 1'b0;
      idle(40);
      chk("rm_cnt", vcnt, 6);
      tx(16, 0, 8'h7E, 1, 10);
      idle(40);
      chk("rm_next_cnt", vcnt, 7);
      chk("rm_next_b", got_q[6], 8'h7E);
      chk("rm_next_byte", byte_a, 8'h7E);
      tx(434, 1, 8'h55, 1, 10);
      idle(100);
      $display("info: default-rate latency %0d cycles", lat_b);
      chk("lat434", (lat_b >= 4122 && lat_b <= 4126), 1);
      chk("b_cnt", vb_cnt, 1);
      chk("b_byte", byte_b, 8'h55);
      chk("b_ferr", fb_cnt, 0);
      chk("pulse_rules", viol, 0);
      chk("ferr_total", fcnt, 1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
